// File: rtl/result_bcd_display_pkg.sv
// Shared definitions for the result display path: FSM states, digit geometry,
// segment constants and the leading-zero mask helper.
package result_bcd_display_pkg;

  typedef enum logic [1:0] {
    D_IDLE,
    D_SHIFT,
    D_DONE
  } disp_state_t;

  localparam int NUM_DIGITS = 5;
  localparam int MAG_BITS   = 15;
  localparam int BCD_BITS   = 4 * NUM_DIGITS;

  // Active-high segments, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  // Scan from the most significant digit down; digit 0 is never blanked.
  function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input logic [BCD_BITS-1:0] bcd);
    logic                  run;
    logic [NUM_DIGITS-1:0] mask;
    run  = 1'b1;
    mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (run && (bcd[i*4 +: 4] == 4'd0)) mask[i] = 1'b1;
      else                                run     = 1'b0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/result_bcd_display_seg7_decode.sv
// Combinational BCD digit to active-high seven-segment pattern (bit0 = a .. bit6 = g).
// Codes above 9 produce all segments off.
module seg7_decode (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (digit)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/result_bcd_display.sv
// Sign-magnitude result to five BCD digits via a sequential double-dabble engine.
// Optional multiplexed seven-segment drive when RESULT_BCD_DISPLAY_SEVSEG_EN is defined.
module result_bcd_display
  import result_bcd_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic [15:0]           result_in,
  input  logic                  complete_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sign_out,
  output logic [BCD_BITS-1:0]   bcd_out,
  output logic [NUM_DIGITS-1:0] blank_mask
`ifdef RESULT_BCD_DISPLAY_SEVSEG_EN
  ,
  output logic [6:0]            seg,
  output logic [5:0]            an
`endif
);

  localparam logic [3:0] LAST_ITER = 4'(MAG_BITS - 1);

  disp_state_t           state;
  logic                  complete_q;
  logic                  trigger;
  logic [MAG_BITS-1:0]   mag_sh;
  logic [BCD_BITS-1:0]   bcd_sh;
  logic [BCD_BITS-1:0]   bcd_adj;
  logic                  sign_cap;
  logic [3:0]            iter;

  assign trigger = complete_in & ~complete_q;

  // Add-3 correction on every nibble in parallel before each shift
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_sh[gi*4 +: 4] >= 4'd5) ? (bcd_sh[gi*4 +: 4] + 4'd3)
                                                            : bcd_sh[gi*4 +: 4];
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= D_IDLE;
      complete_q <= 1'b0;
      mag_sh     <= '0;
      bcd_sh     <= '0;
      sign_cap   <= 1'b0;
      iter       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sign_out   <= 1'b0;
      bcd_out    <= '0;
      blank_mask <= 5'b11110;
    end else begin
      complete_q <= complete_in;
      done       <= 1'b0;
      case (state)
        D_IDLE: begin
          if (trigger) begin
            mag_sh   <= result_in[MAG_BITS-1:0];
            // Negative zero is shown as plain zero
            sign_cap <= result_in[15] & (|result_in[MAG_BITS-1:0]);
            bcd_sh   <= '0;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= D_SHIFT;
          end
        end
        D_SHIFT: begin
          bcd_sh <= {bcd_adj[BCD_BITS-2:0], mag_sh[MAG_BITS-1]};
          mag_sh <= {mag_sh[MAG_BITS-2:0], 1'b0};
          iter   <= iter + 4'd1;
          if (iter == LAST_ITER) begin
            busy  <= 1'b0;
            state <= D_DONE;
          end
        end
        D_DONE: begin
          bcd_out    <= bcd_sh;
          blank_mask <= leading_zero_mask(bcd_sh);
          sign_out   <= sign_cap;
          done       <= 1'b1;
          state      <= D_IDLE;
        end
        default: state <= D_IDLE;
      endcase
    end
  end

`ifdef RESULT_BCD_DISPLAY_SEVSEG_EN
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       slot;
  logic [3:0]       slot_digit;
  logic             slot_blank;
  logic [6:0]       digit_seg;
  logic [6:0]       slot_seg;

  always_comb begin
    slot_digit = 4'd0;
    slot_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == 3'(i)) begin
        slot_digit = bcd_out[i*4 +: 4];
        slot_blank = blank_mask[i];
      end
    end
    if (slot == 3'd5) slot_seg = sign_out ? SEG_MINUS : 7'b0000000;
    else              slot_seg = slot_blank ? 7'b0000000 : digit_seg;
  end

  seg7_decode u_seg7_decode (
    .digit (slot_digit),
    .seg   (digit_seg)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      scan_cnt <= '0;
      slot     <= '0;
      seg      <= '0;
      an       <= '0;
    end else begin
      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        slot     <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= 6'b000001 << slot;
      seg <= slot_seg;
    end
  end
`else
  logic unused_scan_div;
  assign unused_scan_div = (SCAN_DIV > 0);
`endif

endmodule
